// File: rtl/swervolf_sevseg_scanner.sv
// Eight-digit multiplexed seven-segment scanner with per-digit PWM brightness and a blank guard sub-slot.
// Latency: pins are registered one cycle after the scan counters; register updates take effect at the next frame wrap.
// Backpressure: none; i_update is always accepted and held pending (last wins) until the frame boundary.
// Optional: define SEVSEG_ZERO_BLANK_EN to suppress leading zeros on digits 7..1.
module swervolf_sevseg_scanner #(
  parameter int SUBSLOT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(SUBSLOT_CYCLES + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_digit_en,
  input  logic [31:0] i_digits,
  input  logic [7:0]  i_dp,
  input  logic [3:0]  i_brightness,
  input  logic        i_update,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic        o_frame_done,
  output logic        o_busy_pending
);

  typedef struct packed {
    logic [7:0]  en;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [3:0]  bright;
  } disp_t;

  localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'(SUBSLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_ONE = CNT_W'(1);
  localparam disp_t DISP_RST = '{en: 8'h00, digits: 32'h0, dp: 8'h00, bright: 4'hF};

  logic [CNT_W-1:0] cyc;
  logic [3:0]       sub;
  logic [2:0]       dig;
  logic             cyc_wrap;
  logic             sub_wrap;
  logic             frame_wrap;

  disp_t            shadow;
  disp_t            staging;
  disp_t            in_vals;
  logic             pending;

  logic [7:0]       blank;
  logic [3:0]       cur_nib;
  logic             lit;

  // Active-low abc_defg pattern for a hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b1110010;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign cyc_wrap   = (cyc == CYC_MAX);
  assign sub_wrap   = cyc_wrap && (sub == 4'd15);
  assign frame_wrap = sub_wrap && (dig == 3'd7);

  assign in_vals = '{en: i_digit_en, digits: i_digits, dp: i_dp, bright: i_brightness};
  assign o_busy_pending = pending;

  // Free-running scan counters: cycle within sub-slot, sub-slot within digit, digit within frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc <= '0;
      sub <= '0;
      dig <= '0;
    end else begin
      cyc <= cyc_wrap ? '0 : cyc + CYC_ONE;
      if (cyc_wrap) sub <= sub + 4'd1;
      if (sub_wrap) dig <= dig + 3'd1;
    end
  end

  // Update handshake: stage requests, commit to shadow only on the frame wrap so a frame never tears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow  <= DISP_RST;
      staging <= DISP_RST;
      pending <= 1'b0;
    end else if (i_update && frame_wrap) begin
      // A request landing on the wrap cycle itself supersedes anything staged.
      shadow  <= in_vals;
      pending <= 1'b0;
    end else if (i_update) begin
      staging <= in_vals;
      pending <= 1'b1;
    end else if (frame_wrap && pending) begin
      shadow  <= staging;
      pending <= 1'b0;
    end
  end

`ifdef SEVSEG_ZERO_BLANK_EN
  logic zrun;

  // Leading-zero run from digit 7 downward; disabled digits neither blank nor break the run.
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (shadow.en[k]) begin
        if ((shadow.digits[4*k +: 4] == 4'd0) && !shadow.dp[k]) begin
          blank[k] = zrun;
        end else begin
          zrun = 1'b0;
        end
      end
    end
  end
`else
  assign blank = '0;
`endif

  // Current digit is lit in sub-slots 1..brightness; sub-slot 0 is the anti-ghosting guard.
  always_comb begin
    cur_nib = shadow.digits[{dig, 2'b00} +: 4];
    lit     = (sub != 4'd0) && (sub <= shadow.bright) && shadow.en[dig] && !blank[dig];
  end

  // Registered pin drive and frame pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_an         <= 8'hFF;
      o_seg        <= 7'h7F;
      o_dp         <= 1'b1;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= frame_wrap;
      if (lit) begin
        o_an  <= ~(8'h01 << dig);
        o_seg <= seg_decode(cur_nib);
        o_dp  <= ~shadow.dp[dig];
      end else begin
        o_an  <= 8'hFF;
        o_seg <= 7'h7F;
        o_dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_swervolf_sevseg_scanner.sv
// Bench for swervolf_sevseg_scanner: directed scenarios plus randomized updates against a frame-position model.
module tb_swervolf_sevseg_scanner;

  localparam int S     = 4;
  localparam int DIGP  = 16 * S;
  localparam int FRAME = 128 * S;

  typedef struct packed {
    logic [7:0]  en;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [3:0]  bright;
  } disp_t;

  localparam disp_t DEF = '{en: 8'h00, digits: 32'h0, dp: 8'h00, bright: 4'hF};

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_digit_en;
  logic [31:0] i_digits;
  logic [7:0]  i_dp;
  logic [3:0]  i_brightness;
  logic        i_update;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame_done;
  logic        o_busy_pending;

  swervolf_sevseg_scanner #(.SUBSLOT_CYCLES(S)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_digit_en(i_digit_en), .i_digits(i_digits),
    .i_dp(i_dp), .i_brightness(i_brightness), .i_update(i_update),
    .o_an(o_an), .o_seg(o_seg), .o_dp(o_dp),
    .o_frame_done(o_frame_done), .o_busy_pending(o_busy_pending)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int    n_checks = 0;
  int    n_errors = 0;
  int    c = 0;          // cycles since reset release
  disp_t m_sh = DEF;     // values the model believes are displayed
  disp_t m_st = DEF;
  bit    m_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [3:0] nib_of(input disp_t s, input int d);
    logic [31:0] t;
    t = s.digits >> (4 * d);
    return t[3:0];
  endfunction

  // A digit is a suppressed leading zero if it and every enabled digit above it reads as a bare zero.
  function automatic bit zb_blank(input disp_t s, input int d);
`ifdef SEVSEG_ZERO_BLANK_EN
    if (d == 0) return 1'b0;
    if (nib_of(s, d) != 4'd0 || s.dp[d]) return 1'b0;
    for (int j = d + 1; j < 8; j++)
      if (s.en[j] && (nib_of(s, j) != 4'd0 || s.dp[j])) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected {an, seg, dp} for the counter position reached c cycles after reset.
  function automatic logic [15:0] exp_pins(input int cyc_idx, input disp_t s);
    int p, d, sl;
    logic [7:0] an;
    p  = cyc_idx % FRAME;
    d  = p / DIGP;
    sl = (p / S) % 16;
    if (sl >= 1 && sl <= int'(s.bright) && s.en[d] && !zb_blank(s, d)) begin
      an = 8'hFF & ~(8'h01 << d);
      return {an, seg_tab[nib_of(s, d)], ~s.dp[d]};
    end
    return 16'hFFFF;
  endfunction

  function automatic disp_t rand_disp();
    disp_t v;
    v.en     = 8'($urandom);
    v.digits = $urandom;
    v.dp     = 8'($urandom);
    v.bright = 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic step(input bit upd, input disp_t v, input bit rst);
    logic [15:0] e_pins;
    bit          wrap;
    @(negedge i_clk);
    i_rst        = rst;
    i_update     = upd;
    i_digit_en   = v.en;
    i_digits     = v.digits;
    i_dp         = v.dp;
    i_brightness = v.bright;
    e_pins = exp_pins(c, m_sh);
    wrap   = ((c % FRAME) == FRAME - 1);
    @(posedge i_clk);
    #1;
    if (rst) begin
      m_sh = DEF; m_st = DEF; m_pend = 1'b0; c = 0;
      e_pins = 16'hFFFF; wrap = 1'b0;
    end else begin
      if (upd && wrap) begin
        m_sh = v; m_pend = 1'b0;
      end else if (upd) begin
        m_st = v; m_pend = 1'b1;
      end else if (wrap && m_pend) begin
        m_sh = m_st; m_pend = 1'b0;
      end
      c++;
    end
    chk("pins", 32'({o_an, o_seg, o_dp}), 32'(e_pins));
    chk("frame_done", 32'(o_frame_done), 32'(wrap));
    chk("busy_pending", 32'(o_busy_pending), 32'(m_pend));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rand_disp(), 1'b0);
  endtask

  task automatic load(input disp_t v);
    step(1'b1, v, 1'b0);
  endtask

  task automatic run_to_wrap();
    for (int i = 0; i < FRAME && (c % FRAME) != FRAME - 1; i++) step(1'b0, rand_disp(), 1'b0);
  endtask

  initial begin
    i_rst = 1'b1; i_update = 1'b0;
    i_digit_en = '0; i_digits = '0; i_dp = '0; i_brightness = '0;

    // Reset state, then two dark frames with frame pulses.
    step(1'b0, DEF, 1'b1);
    step(1'b0, DEF, 1'b1);
    idle(2 * FRAME);

    // Single digit 3 at full brightness.
    load('{en: 8'h01, digits: 32'h0000_0003, dp: 8'h00, bright: 4'hF});
    idle(FRAME + 200);

    // All digits at quarter duty.
    load('{en: 8'hFF, digits: 32'h7654_3210, dp: 8'h00, bright: 4'h4});
    idle(FRAME + 100);

    // Two requests within a frame: only the second reaches the display.
    idle(100);
    load('{en: 8'hFF, digits: 32'hAAAA_AAAA, dp: 8'hFF, bright: 4'hF});
    idle(50);
    load('{en: 8'h5A, digits: 32'hFEDC_BA98, dp: 8'h0F, bright: 4'h9});
    idle(FRAME);

    // Request exactly on the wrap cycle loads at once.
    run_to_wrap();
    load('{en: 8'hC3, digits: 32'h1234_5678, dp: 8'h81, bright: 4'hC});
    idle(FRAME / 2);

    // Reset mid-frame with an update pending.
    idle(37);
    load('{en: 8'hFF, digits: 32'h8888_8888, dp: 8'hFF, bright: 4'hF});
    idle(20);
    step(1'b0, DEF, 1'b1);
    idle(FRAME + 50);

    // Brightness zero: dark, scanning and pulses continue.
    load('{en: 8'hFF, digits: 32'h1111_1111, dp: 8'hFF, bright: 4'h0});
    idle(FRAME + 50);

    // Leading-zero patterns.
    load('{en: 8'hFF, digits: 32'h0000_0120, dp: 8'h00, bright: 4'hF});
    idle(FRAME + 50);
    load('{en: 8'hFF, digits: 32'h0000_0120, dp: 8'h20, bright: 4'hF});
    idle(FRAME + 50);
    load('{en: 8'hBF, digits: 32'h0000_0100, dp: 8'h00, bright: 4'hF});
    idle(FRAME + 50);

    // Randomized update traffic, including occasional wrap-cycle hits.
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 199) == 0) load(rand_disp());
      else if ((c % FRAME) == FRAME - 1 && $urandom_range(0, 2) == 0) load(rand_disp());
      else step(1'b0, rand_disp(), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
